// File: rtl/cpu_types_pkg.sv
// Shared MIPS datapath types and the ID/EX payload carried by the pipeline latch.
package cpu_types_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned ALUOP_W = 4;
   localparam int unsigned IMM_W   = 16;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_SLL  = 4'b0000,
      ALU_SRL  = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0011,
      ALU_AND  = 4'b0100,
      ALU_OR   = 4'b0101,
      ALU_XOR  = 4'b0110,
      ALU_NOR  = 4'b0111,
      ALU_SLT  = 4'b1010,
      ALU_SLTU = 4'b1011
   } aluop_t;

   typedef struct packed {
      word_t             pc4;
      word_t             rdat1;
      word_t             rdat2;
      logic [IMM_W-1:0]  imm;
      regbits_t          rs;
      regbits_t          rt;
      regbits_t          rd;
      regbits_t          shamt;
      logic [1:0]        tmpPC;
      logic [1:0]        RegDest;
      logic [1:0]        MemtoReg;
      aluop_t            ALUOP;
      logic              branch;
      logic              RegWEN;
      logic              ALUSrc;
      logic              ExtOp;
      logic              halt;
      logic              dmemREN;
      logic              dmemWEN;
   } id_ex_t;

endpackage

// File: rtl/id_ex_latch_if.sv
// Decode-side inputs, execute-side outputs and hazard signals of the ID/EX latch.
interface id_ex_if;
   import cpu_types_pkg::*;

   logic        ihit;
   logic        mem_busy;
   logic        flush;

   word_t       id_pc4, id_rdat1, id_rdat2;
   logic [15:0] id_imm;
   regbits_t    id_rs, id_rt, id_rd, id_shamt;
   logic [1:0]  id_tmpPC, id_RegDest, id_MemtoReg;
   aluop_t      id_ALUOP;
   logic        id_branch, id_RegWEN, id_ALUSrc, id_ExtOp, id_halt, id_dmemREN, id_dmemWEN;

   word_t       ex_pc4, ex_rdat1, ex_rdat2;
   logic [15:0] ex_imm;
   regbits_t    ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [1:0]  ex_tmpPC, ex_RegDest, ex_MemtoReg;
   aluop_t      ex_ALUOP;
   logic        ex_branch, ex_RegWEN, ex_ALUSrc, ex_ExtOp, ex_halt, ex_dmemREN, ex_dmemWEN;
   logic        ex_valid;
   regbits_t    ex_wsel;
   logic        stall;

   modport master (
      output ihit, mem_busy, flush,
      output id_pc4, id_rdat1, id_rdat2, id_imm, id_rs, id_rt, id_rd, id_shamt,
      output id_tmpPC, id_RegDest, id_MemtoReg, id_ALUOP,
      output id_branch, id_RegWEN, id_ALUSrc, id_ExtOp, id_halt, id_dmemREN, id_dmemWEN,
      input  ex_pc4, ex_rdat1, ex_rdat2, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt,
      input  ex_tmpPC, ex_RegDest, ex_MemtoReg, ex_ALUOP,
      input  ex_branch, ex_RegWEN, ex_ALUSrc, ex_ExtOp, ex_halt, ex_dmemREN, ex_dmemWEN,
      input  ex_valid, ex_wsel, stall
   );

   modport slave (
      input  ihit, mem_busy, flush,
      input  id_pc4, id_rdat1, id_rdat2, id_imm, id_rs, id_rt, id_rd, id_shamt,
      input  id_tmpPC, id_RegDest, id_MemtoReg, id_ALUOP,
      input  id_branch, id_RegWEN, id_ALUSrc, id_ExtOp, id_halt, id_dmemREN, id_dmemWEN,
      output ex_pc4, ex_rdat1, ex_rdat2, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt,
      output ex_tmpPC, ex_RegDest, ex_MemtoReg, ex_ALUOP,
      output ex_branch, ex_RegWEN, ex_ALUSrc, ex_ExtOp, ex_halt, ex_dmemREN, ex_dmemWEN,
      output ex_valid, ex_wsel, stall
   );

endinterface

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use stall detection, flush/stall bubbles
// and a sticky HALT that blocks every younger instruction until reset.
module id_ex_latch
   import cpu_types_pkg::*;
(
   input logic    CLK,
   input logic    RST,
   id_ex_if.slave bus
);

   id_ex_t   r_ex, w_ex_nxt, w_id;
   logic     r_valid, w_valid_nxt;
   regbits_t r_wsel, w_wsel_nxt, w_wsel_dec;
   logic     r_halted, w_halted_nxt;
   logic     w_uses_rs, w_uses_rt, w_stall;

   // Gather decode inputs into one payload
   always_comb begin
      w_id          = '0;
      w_id.pc4      = bus.id_pc4;
      w_id.rdat1    = bus.id_rdat1;
      w_id.rdat2    = bus.id_rdat2;
      w_id.imm      = bus.id_imm;
      w_id.rs       = bus.id_rs;
      w_id.rt       = bus.id_rt;
      w_id.rd       = bus.id_rd;
      w_id.shamt    = bus.id_shamt;
      w_id.tmpPC    = bus.id_tmpPC;
      w_id.RegDest  = bus.id_RegDest;
      w_id.MemtoReg = bus.id_MemtoReg;
      w_id.ALUOP    = bus.id_ALUOP;
      w_id.branch   = bus.id_branch;
      w_id.RegWEN   = bus.id_RegWEN;
      w_id.ALUSrc   = bus.id_ALUSrc;
      w_id.ExtOp    = bus.id_ExtOp;
      w_id.halt     = bus.id_halt;
      w_id.dmemREN  = bus.id_dmemREN;
      w_id.dmemWEN  = bus.id_dmemWEN;
   end

   // Destination select; the undefined RegDest encoding writes nowhere
   always_comb begin
      w_wsel_dec = '0;
      case (bus.id_RegDest)
         2'd0:    w_wsel_dec = bus.id_rd;
         2'd1:    w_wsel_dec = bus.id_rt;
         2'd2:    w_wsel_dec = REG_W'(31);
         default: w_wsel_dec = '0;
      endcase
   end

   // Load-use hazard against the load currently in EX
   assign w_uses_rs = (bus.id_tmpPC != 2'd2) && (bus.id_MemtoReg != 2'd2);
   assign w_uses_rt = !bus.id_ALUSrc || bus.id_dmemWEN;
   assign w_stall   = r_valid && r_ex.dmemREN && r_ex.RegWEN && (r_wsel != '0)
                    && ((w_uses_rs && (r_wsel == bus.id_rs)) ||
                        (w_uses_rt && (r_wsel == bus.id_rt)))
                    && !bus.flush && !r_halted;

   // Next state: hold on mem_busy, otherwise load only a fresh, unblocked instruction
   always_comb begin
      w_ex_nxt     = r_ex;
      w_valid_nxt  = r_valid;
      w_wsel_nxt   = r_wsel;
      w_halted_nxt = r_halted;
      if (!bus.mem_busy) begin
         w_ex_nxt    = '0;
         w_valid_nxt = 1'b0;
         w_wsel_nxt  = '0;
         if (!r_halted && !bus.flush && !w_stall && bus.ihit) begin
            w_ex_nxt     = w_id;
            w_valid_nxt  = 1'b1;
            w_wsel_nxt   = w_wsel_dec;
            w_halted_nxt = bus.id_halt;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ex     <= '0;
         r_valid  <= 1'b0;
         r_wsel   <= '0;
         r_halted <= 1'b0;
      end else begin
         r_ex     <= w_ex_nxt;
         r_valid  <= w_valid_nxt;
         r_wsel   <= w_wsel_nxt;
         r_halted <= w_halted_nxt;
      end
   end

   assign bus.ex_pc4      = r_ex.pc4;
   assign bus.ex_rdat1    = r_ex.rdat1;
   assign bus.ex_rdat2    = r_ex.rdat2;
   assign bus.ex_imm      = r_ex.imm;
   assign bus.ex_rs       = r_ex.rs;
   assign bus.ex_rt       = r_ex.rt;
   assign bus.ex_rd       = r_ex.rd;
   assign bus.ex_shamt    = r_ex.shamt;
   assign bus.ex_tmpPC    = r_ex.tmpPC;
   assign bus.ex_RegDest  = r_ex.RegDest;
   assign bus.ex_MemtoReg = r_ex.MemtoReg;
   assign bus.ex_ALUOP    = r_ex.ALUOP;
   assign bus.ex_branch   = r_ex.branch;
   assign bus.ex_RegWEN   = r_ex.RegWEN;
   assign bus.ex_ALUSrc   = r_ex.ALUSrc;
   assign bus.ex_ExtOp    = r_ex.ExtOp;
   assign bus.ex_halt     = r_ex.halt;
   assign bus.ex_dmemREN  = r_ex.dmemREN;
   assign bus.ex_dmemWEN  = r_ex.dmemWEN;
   assign bus.ex_valid    = r_valid;
   assign bus.ex_wsel     = r_wsel;
   assign bus.stall       = w_stall;

endmodule
